// File: rtl/sll_seq_if.sv
// Request/result bundle for the iterative left shifter.
// The master issues start/A/shiftAmount; the slave returns the result and status.
interface sll_seq_if #(
    parameter int WIDTH = 16
);
    localparam int CntW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [CntW-1:0]  shiftAmount;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output A,
        output shiftAmount,
        input  out,
        input  carry,
        input  overflow,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  shiftAmount,
        output out,
        output carry,
        output overflow,
        output busy,
        output done
    );
endinterface

// File: rtl/sll_seq.sv
// Iterative left shifter: one bit per clock, zero fill,
// with carry-out, sticky sign-change overflow and a done pulse.
module sll_seq #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst_n,
    sll_seq_if.slave  bus
);
    localparam int CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Shift = 2'd1,
        Done  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] outReg;
    logic [CntW-1:0]  cnt;
    logic             carryReg;
    logic             ovfReg;
    logic             busyReg;
    logic             doneReg;

    logic             msb;
    logic             nextMsb;

    assign msb     = outReg[WIDTH-1];
    assign nextMsb = outReg[WIDTH-2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= Idle;
            outReg   <= '0;
            cnt      <= '0;
            carryReg <= 1'b0;
            ovfReg   <= 1'b0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            unique case (state)
                Idle: begin
                    if (bus.start) begin
                        outReg   <= bus.A;
                        cnt      <= bus.shiftAmount;
                        carryReg <= 1'b0;
                        ovfReg   <= 1'b0;
                        busyReg  <= 1'b1;
                        if (bus.shiftAmount == '0) begin
                            state   <= Done;
                            doneReg <= 1'b1;
                        end else begin
                            state   <= Shift;
                        end
                    end
                end
                Shift: begin
                    // Overflow whenever a shift would flip the sign bit.
                    outReg   <= {outReg[WIDTH-2:0], 1'b0};
                    carryReg <= msb;
                    ovfReg   <= ovfReg | (msb ^ nextMsb);
                    cnt      <= cnt - CntW'(1);
                    if (cnt == CntW'(1)) begin
                        state   <= Done;
                        doneReg <= 1'b1;
                    end
                end
                Done: begin
                    state   <= Idle;
                    doneReg <= 1'b0;
                    busyReg <= 1'b0;
                end
                default: begin
                    state   <= Idle;
                    doneReg <= 1'b0;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out      = outReg;
    assign bus.carry    = carryReg;
    assign bus.overflow = ovfReg;
    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
endmodule
